// File: rtl/seg_pkg.sv
// Shared types and helpers for the 8-digit seven-segment scan driver.
package seg_pkg;

  localparam int DIGITS = 8;

  typedef logic [2:0] digit_idx_t;
  typedef logic [3:0] nibble_t;

  localparam logic [7:0] ALL_OFF = 8'h00;

  function automatic nibble_t get_nibble(input logic [31:0] value, input digit_idx_t k);
    return value[{k, 2'b00} +: 4];
  endfunction

  // Digit k is a leading zero when it and every more significant nibble are zero;
  // digit 0 always stays lit so a zero value still reads "0".
  function automatic logic lz_blanked(input logic [31:0] value, input digit_idx_t k);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if (j >= int'(k) && value[4*j +: 4] != 4'h0) upper_zero = 1'b0;
    end
    return upper_zero && (k != '0);
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Modulo-DIV free-running counter; tick marks the last count of each period.
module scan_prescaler #(
  parameter int DIV = 100000,
  parameter int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [CW-1:0] cnt,
  output logic          tick
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CW'(DIV - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit scanner with tear-free frame update, per-digit
// enable, leading-zero blanking and a dark guard interval at each slot start.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int GUARD    = 16,
  parameter int DIGITS   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       data,
  input  logic              load,
  input  logic [DIGITS-1:0] digit_en,
  input  logic              lz_en,
  output nibble_t           num,
  output logic [DIGITS-1:0] an,
  output logic              frame_start
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          tick;
  logic          frame_end;

  digit_idx_t        idx_q, idx_d;
  logic [31:0]       pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic [31:0]       disp_q, disp_d;
  nibble_t           num_q, num_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              fs_q, fs_d;

  scan_prescaler #(.DIV(SCAN_DIV), .CW(CW)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt   (cnt),
    .tick  (tick)
  );

  assign frame_end = tick && (idx_q == digit_idx_t'(DIGITS - 1));

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    idx_d      = idx_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    disp_d     = disp_q;
    fs_d       = frame_end;

    if (tick) idx_d = frame_end ? '0 : idx_q + 1'b1;

    if (load) begin
      pend_d     = data;
      pend_vld_d = 1'b1;
    end

    // Evaluated after the load so a strobe on the frame-end tick is taken at once.
    if (frame_end && pend_vld_d) begin
      disp_d     = pend_d;
      pend_vld_d = 1'b0;
    end

    num_d = get_nibble(disp_q, idx_q);
    if (cnt < CW'(GUARD) || !digit_en[idx_q] || (lz_en && lz_blanked(disp_q, idx_q)))
      an_d = ALL_OFF;
    else
      an_d = DIGITS'(1) << idx_q;
  end

  // NOTE: the pending/display registers are plain flops (not a memory), so
  // they take the asynchronous reset like the rest of the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      disp_q     <= '0;
      num_q      <= '0;
      an_q       <= ALL_OFF;
      fs_q       <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      disp_q     <= disp_d;
      num_q      <= num_d;
      an_q       <= an_d;
      fs_q       <= fs_d;
    end
  end

  assign num         = num_q;
  assign an          = an_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench: the stimulus process predicts each cycle's outputs from a
// time-based display model; an independent monitor pops and compares them.
module tb_seg_scan_driver;

  localparam int SCAN_DIV = 4;
  localparam int GUARD    = 1;
  localparam int FRAME    = SCAN_DIV * 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data = '0;
  logic        load = 1'b0;
  logic [7:0]  digit_en = 8'hFF;
  logic        lz_en = 1'b0;
  logic [3:0]  num;
  logic [7:0]  an;
  logic        frame_start;

  typedef struct packed {
    logic [3:0] num;
    logic [7:0] an;
    logic       fs;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model state: t = clock edges since reset release.
  int          t;
  logic [31:0] m_disp, m_pend;
  bit          m_pv;

  seg_scan_driver #(.SCAN_DIV(SCAN_DIV), .GUARD(GUARD), .DIGITS(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data        (data),
    .load        (load),
    .digit_en    (digit_en),
    .lz_en       (lz_en),
    .num         (num),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0d, time %0t)", name, act, exp, t, $time);
    end
  endtask

  function automatic logic [7:0] model_an(input int tt, input logic [7:0] den, input bit lz,
                                          input logic [31:0] disp);
    int d;
    d = (tt / SCAN_DIV) % 8;
    if (tt % SCAN_DIV < GUARD) return 8'h00;
    if (!den[d]) return 8'h00;
    if (lz && d > 0 && (disp >> (4 * d)) == 32'h0) return 8'h00;
    return 8'(1 << d);
  endfunction

  task automatic reset_model();
    t = 0; m_disp = '0; m_pend = '0; m_pv = 0;
  endtask

  // Drive inputs for cycle t, predict the outputs seen after the next edge.
  task automatic step(input bit ld, input logic [31:0] dv, input logic [7:0] den, input bit lz);
    exp_t e;
    int   d;
    @(negedge clk);
    load = ld; data = dv; digit_en = den; lz_en = lz;
    d     = (t / SCAN_DIV) % 8;
    e.num = m_disp[4*d +: 4];
    e.an  = model_an(t, den, lz, m_disp);
    e.fs  = ((t + 1) % FRAME == 0);
    exp_q.push_back(e);
    if (ld) begin m_pend = dv; m_pv = 1; end
    if (t % FRAME == FRAME - 1 && m_pv) begin m_disp = m_pend; m_pv = 0; end
    t++;
  endtask

  function automatic logic [31:0] rand_data();
    logic [63:0] v;
    v = 64'($urandom) >> (4 * $urandom_range(0, 8));
    return v[31:0];
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("num", 32'(num), 32'(e.num));
        check("an", 32'(an), 32'(e.an));
        check("frame_start", 32'(frame_start), 32'(e.fs));
      end
    end
  end

  initial begin : stimulus
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    check("reset_num", 32'(num), 32'h0);
    check("reset_an", 32'(an), 32'h0);
    check("reset_frame_start", 32'(frame_start), 32'h0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Plain scan: frame 0 shows zeros, frame 1 shows F..8.
    step(1, 32'h89AB_CDEF, 8'hFF, 0);
    repeat (63) step(0, 32'h0, 8'hFF, 0);

    // Leading-zero blanking on 0x0A05, then on 0.
    for (int i = 0; i < 64; i++) step(i == 0, 32'h0000_0A05, 8'hFF, 1);
    for (int i = 0; i < 64; i++) step(i == 0, 32'h0, 8'hFF, 1);

    // Even digits disabled.
    for (int i = 0; i < 64; i++) step(i == 0, 32'h89AB_CDEF, 8'b1010_1010, 0);

    // Tear-free update: two loads in one frame, then one on the frame-end tick.
    for (int i = 0; i < 96; i++) begin
      logic [31:0] dv;
      dv = (i == 10) ? 32'h1111_1111 : (i == 20) ? 32'h2222_2222 : 32'h3333_3333;
      step((i == 10) || (i == 20) || (i == 63), dv, 8'hFF, 0);
    end

    // Randomised traffic.
    repeat (300) begin
      logic [7:0] den;
      den = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      step($urandom_range(0, 11) == 0, rand_data(), den, bit'($urandom_range(0, 1)));
    end

    // Reset asserted mid-slot at digit 5.
    while (!(((t / SCAN_DIV) % 8 == 5) && (t % SCAN_DIV == 2))) step(0, 32'h0, 8'hFF, 0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midreset_an", 32'(an), 32'h0);
    check("midreset_num", 32'(num), 32'h0);
    check("midreset_frame_start", 32'(frame_start), 32'h0);
    reset_model();
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (64) step(0, 32'h0, 8'hFF, 0);

    @(posedge clk); #2;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Time-multiplexed scanner for the 8-digit common-cathode seven-segment display. It holds a 32-bit value as 8 hex nibbles and cycles through the digits at a fixed scan rate. Each cycle it presents one nibble on `num` for the downstream hex-to-segment decoder `num2LED`, and drives the matching active-high digit select `an`. It adds frame-synchronous update, per-digit enable, leading-zero blanking and an anti-ghosting guard interval.

Parameters:
- SCAN_DIV, 100000, clock cycles per digit slot (100 MHz gives 1 kHz per digit); must be >= GUARD+2
- GUARD, 16, cycles at the start of each slot during which all digit selects are forced off
- DIGITS, 8, number of digits scanned; fixed at 8 for this board, index width 3

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- data  in  32  value to display; nibble k = data[4k+3:4k]; digit 0 is rightmost
- load  in  1  one-cycle strobe; captures data into the pending register
- digit_en  in  8  per-digit enable, bit k enables digit k
- lz_en  in  1  1 = blank leading zero digits
- num  out  4  nibble for the current digit, feeds num2LED
- an  out  8  digit select, one-hot active-high, all-zero when blanked
- frame_start  out  1  one-cycle pulse when the digit index wraps to 0

Behaviour:
- Reset: one clock domain (`clk`); reset `rst_n` is asynchronous and active-low. While `rst_n` = 0:
  - prescaler `cnt` = 0, digit index `idx` = 0
  - pending register = 0, display register = 0, pending-valid flag = 0
  - `num` = 4'h0, `an` = 8'h00, `frame_start` = 0
- Prescaler:
  - `cnt` counts 0..SCAN_DIV-1, then wraps to 0.
  - `tick` = (`cnt` == SCAN_DIV-1).
- Digit index: on `tick`, `idx` <= (`idx` == 7) ? 0 : `idx`+1.
- `frame_start`: registered; asserted for exactly the one cycle in which `cnt` == 0 and `idx` == 0 after a wrap (not after reset).
- Load and frame-synchronous update:
  - `load` = 1: pending <= `data`, pending-valid <= 1.
  - On a `tick` with `idx` == 7 (frame end) and pending-valid = 1: display <= pending, pending-valid <= 0.
  - Simultaneous `load` and frame-end tick: display takes the *new* `data`, pending-valid ends at 0.
  - Multiple loads within one frame: the last one wins.
- Leading-zero blanking: digit k is blanked when `lz_en` = 1, display[4k+3:4k] == 0, and all higher nibbles are 0. Digit 0 is never blanked by this rule, so the value 0 shows as "0".
- Outputs, registered, one cycle latency from `cnt`/`idx`:
  - `num` <= display nibble[`idx`].
  - `an` <= 0 if `cnt` < GUARD, or `digit_en`[`idx`] = 0, or the digit is LZ-blanked.
  - Otherwise `an` <= 1 << `idx`.
  - `an` is never multi-hot.
- `digit_en` and `lz_en` changes take effect at the next output register update; no frame synchronisation.
- Reset mid-scan: all state clears immediately (asynchronous). The first digit slot after release starts at `idx` 0 with the guard interval applied.

Decomposition:
- Package `seg_pkg`:
  - DIGITS = 8
  - `digit_idx_t` (3-bit)
  - `nibble_t` (4-bit)
  - localparam `ALL_OFF` = 8'h00
- Natural sub-module: `scan_prescaler` (parameterised modulo counter emitting `tick`).
- The top-level display wrapper instantiates seg_scan_driver followed by `num2LED` (num -> DISP). num2LED is not instantiated inside this block.

Test Plan (SCAN_DIV=4, GUARD=1):
- Reset release, `data`=32'h89ABCDEF, `load`, `digit_en`=FF, `lz_en`=0:
  - Before the first frame end, `an` stays 0 in guard cycles, then walks 01,02,...,80 with `num`=0.
  - After the first frame end, slot k shows `num` = F,E,D,C,B,A,9,8 for k=0..7.
- Guard check: in every slot, the first output cycle has `an`=00 and the following 3 cycles have `an`=one-hot; `frame_start` pulses once per 32 cycles.
- `lz_en`=1, display=32'h0000_0A05:
  - digits 0..2 light with `num` 5,0,A; digits 3..7 `an`=00.
  - display=0: only digit 0 lights, with `num`=0.
- `digit_en`=8'b1010_1010: digits 0,2,4,6 never assert `an`; odd digits unaffected.
- Tear-free update: `load` 32'h11111111 mid-frame, then `load` 32'h22222222 in the same frame:
  - the current frame still shows the old value
  - the next frame shows all 2s.
  - `load` coincident with the idx=7 tick: the new value is shown from the next frame.
- Assert `rst_n`=0 mid-slot at `idx`=5: `an`=00 and `num`=0 the same cycle; after release, scanning restarts at `idx`=0 and display=0.
